snake_motion_controller: RTL and testbench
==========================================

# snake_motion_controller

Advances the snake body one grid cell per move tick in the direction given by the 2-bit navigation state from the navigation state machine. Holds head and body segment coordinates, wraps at the grid edges, grows on reaching the target, detects self-collision, and answers per-pixel "is snake" queries for the VGA renderer. Sits directly downstream of the navigation state machine and upstream of the VGA colour mux and master game state machine.

## Interface
- GRID_X, 160: grid width in cells (x range 0..GRID_X-1)
- GRID_Y, 120: grid height in cells (y range 0..GRID_Y-1)
- X_WIDTH, 8: x coordinate width
- Y_WIDTH, 7: y coordinate width
- MAX_LEN, 16: number of segment registers (maximum length)
- INIT_LEN, 4: length after reset (2..MAX_LEN)
- MOVE_PERIOD, 5000000: CLK cycles per move (20 moves/s at 100 MHz)

- CLK  input  1  system clock; all state changes on its rising edge
- RESET  input  1  synchronous, active-high reset
- NAV_STATE  input  2  direction: 0 UP, 1 LEFT, 2 RIGHT, 3 DOWN
- GAME_ACTIVE  input  1  from master FSM; movement only while high
- TARGET_X  input  X_WIDTH  target cell x
- TARGET_Y  input  Y_WIDTH  target cell y
- ADDR_X  input  X_WIDTH  queried cell x (from VGA)
- ADDR_Y  input  Y_WIDTH  queried cell y
- HEAD_X  output  X_WIDTH  segment 0 x
- HEAD_Y  output  Y_WIDTH  segment 0 y
- LENGTH  output  5  current length (clog2(MAX_LEN)+1 bits)
- MOVE_TICK  output  1  one-cycle pulse, cycle in which a move is evaluated
- TARGET_REACHED  output  1  one-cycle pulse after a growing move
- COLLISION  output  1  sticky self-collision flag
- SNAKE_PIXEL  output  1  registered: query cell is occupied

## Operation
- Reset: seg[i] = (GRID_X/2, GRID_Y/2 + i) for i < INIT_LEN; seg[i] for i >= INIT_LEN = seg[INIT_LEN-1]; LENGTH = INIT_LEN; move counter 0; MOVE_TICK, TARGET_REACHED, COLLISION, SNAKE_PIXEL = 0. Reset has priority over everything, including mid-move.
- Move counter: increments while GAME_ACTIVE=1 and COLLISION=0, else holds. At MOVE_PERIOD-1 it wraps to 0 and MOVE_TICK=1 that cycle.
- New head on a tick (NAV_STATE sampled in the tick cycle): UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1. Wrap: y=0 UP -> GRID_Y-1; y=GRID_Y-1 DOWN -> 0; x=0 LEFT -> GRID_X-1; x=GRID_X-1 RIGHT -> 0. No reversal filtering (upstream FSM forbids it).
- grow = (new head == (TARGET_X, TARGET_Y)) and LENGTH < MAX_LEN.
- hit = new head equals old seg[i] for any 1 <= i <= LENGTH-2 (no grow) or 1 <= i <= LENGTH-1 (grow); vacated tail excluded.
- hit: COLLISION <= 1, segments and LENGTH frozen, no TARGET_REACHED. Collision wins over grow.
- Otherwise: seg[i] <= seg[i-1] for i >= 1, seg[0] <= new head; if grow, LENGTH <= LENGTH+1 and TARGET_REACHED <= 1 for one cycle. Target hit at LENGTH = MAX_LEN: move only, no growth, no pulse.
- COLLISION cleared only by RESET.
- SNAKE_PIXEL <= 1 iff (ADDR_X, ADDR_Y) equals seg[i] for some i < LENGTH.

## Timing
- MOVE_TICK high in cycle T; HEAD_X/HEAD_Y, LENGTH, COLLISION updated at edge ending T; TARGET_REACHED high in T+1 only.
- NAV_STATE changes between ticks have no effect until the next tick.
- GAME_ACTIVE low mid-period: counter freezes, resumes from same value.
- SNAKE_PIXEL latency 1 cycle from ADDR_X/ADDR_Y; reflects segment state as of the sampling edge.
- Segment update on tick and pixel query in same cycle: query sees pre-move segments.

## Test plan
- MOVE_PERIOD=4, GRID 160x120, reset, GAME_ACTIVE=1, NAV_STATE=0 -> MOVE_TICK every 4th cycle; after 1st tick HEAD=(80,59), LENGTH=4, seg[3]=(80,62).
- Head at (0,10), NAV_STATE=1, tick -> HEAD=(159,10); head at (5,119), NAV_STATE=3 -> HEAD=(5,0).
- TARGET=(80,59), first tick from reset -> LENGTH=5, TARGET_REACHED high exactly one cycle after MOVE_TICK; tail still (80,63).
- Steer UP, LEFT, DOWN, RIGHT with LENGTH=5 -> fourth move lands on body, COLLISION=1, HEAD unchanged, no further MOVE_TICK; only RESET clears.
- GAME_ACTIVE low for 10 cycles mid-period -> no MOVE_TICK, counter resumes; RESET asserted 1 cycle after a tick -> all outputs return to reset values next edge.
- ADDR=(80,62) after reset -> SNAKE_PIXEL=1 one cycle later; ADDR=(80,64) -> 0; ADDR=(81,60) -> 0.

Source files
------------

// File: rtl/snake_motion_controller.sv
// snake_motion_controller
//   Moves the snake one grid cell per move period in the direction given by
//   the navigation FSM, wrapping at the grid edges. Grows by one segment when
//   the new head lands on the target, latches a sticky self-collision flag, and
//   answers registered per-cell occupancy queries for the VGA renderer.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   NAV_STATE[1:0]        0 UP, 1 LEFT, 2 RIGHT, 3 DOWN (sampled on the tick)
//   GAME_ACTIVE           movement enable from the master FSM
//   TARGET_X/TARGET_Y     target cell
//   ADDR_X/ADDR_Y         queried cell from the VGA renderer
//   HEAD_X/HEAD_Y         segment 0 coordinates
//   LENGTH                current snake length
//   MOVE_TICK             high in the cycle a move is evaluated
//   TARGET_REACHED        one-cycle pulse after a growing move
//   COLLISION             sticky self-collision flag
//   SNAKE_PIXEL           registered: queried cell is part of the snake
module snake_motion_controller #(
    parameter int GRID_X      = 160,
    parameter int GRID_Y      = 120,
    parameter int X_WIDTH     = 8,
    parameter int Y_WIDTH     = 7,
    parameter int MAX_LEN     = 16,
    parameter int INIT_LEN    = 4,
    parameter int MOVE_PERIOD = 5000000,
    localparam int LW         = $clog2(MAX_LEN) + 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [1:0]         NAV_STATE,
    input  logic               GAME_ACTIVE,
    input  logic [X_WIDTH-1:0] TARGET_X,
    input  logic [Y_WIDTH-1:0] TARGET_Y,
    input  logic [X_WIDTH-1:0] ADDR_X,
    input  logic [Y_WIDTH-1:0] ADDR_Y,
    output logic [X_WIDTH-1:0] HEAD_X,
    output logic [Y_WIDTH-1:0] HEAD_Y,
    output logic [LW-1:0]      LENGTH,
    output logic               MOVE_TICK,
    output logic               TARGET_REACHED,
    output logic               COLLISION,
    output logic               SNAKE_PIXEL
);

    localparam int CW = $clog2(MOVE_PERIOD + 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    logic [X_WIDTH-1:0] seg_x_q [MAX_LEN];
    logic [X_WIDTH-1:0] seg_x_d [MAX_LEN];
    logic [Y_WIDTH-1:0] seg_y_q [MAX_LEN];
    logic [Y_WIDTH-1:0] seg_y_d [MAX_LEN];
    logic [LW-1:0]      len_q, len_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               coll_q, coll_d;
    logic               tr_q, tr_d;
    logic               pix_q, pix_d;

    logic               tick;
    logic [X_WIDTH-1:0] new_x;
    logic [Y_WIDTH-1:0] new_y;
    logic               grow;
    logic               hit;
    logic [LW-1:0]      hit_lim;

    always_comb begin
        // Counter only runs while the game is live and the snake is intact.
        tick  = GAME_ACTIVE & ~coll_q & (cnt_q == CW'(MOVE_PERIOD - 1));
        cnt_d = cnt_q;
        if (GAME_ACTIVE && !coll_q)
            cnt_d = tick ? '0 : cnt_q + 1'b1;

        new_x = seg_x_q[0];
        new_y = seg_y_q[0];
        case (NAV_STATE)
            DIR_UP:    new_y = (seg_y_q[0] == '0) ? Y_WIDTH'(GRID_Y - 1) : seg_y_q[0] - 1'b1;
            DIR_DOWN:  new_y = (seg_y_q[0] == Y_WIDTH'(GRID_Y - 1)) ? '0 : seg_y_q[0] + 1'b1;
            DIR_LEFT:  new_x = (seg_x_q[0] == '0) ? X_WIDTH'(GRID_X - 1) : seg_x_q[0] - 1'b1;
            DIR_RIGHT: new_x = (seg_x_q[0] == X_WIDTH'(GRID_X - 1)) ? '0 : seg_x_q[0] + 1'b1;
            default: ;
        endcase

        grow = (new_x == TARGET_X) && (new_y == TARGET_Y) && (len_q < LW'(MAX_LEN));

        // The tail cell is vacated by a normal move, so it only counts as
        // body when the snake grows and the tail stays put.
        hit_lim = grow ? len_q : len_q - 1'b1;
        hit     = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            if (LW'(i) < hit_lim && seg_x_q[i] == new_x && seg_y_q[i] == new_y)
                hit = 1'b1;

        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        len_d   = len_q;
        coll_d  = coll_q;
        tr_d    = 1'b0;
        if (tick) begin
            if (hit) begin
                coll_d = 1'b1;
            end else begin
                // Shift every register; slots past LENGTH just carry stale
                // copies, which makes a grown tail fall out naturally.
                for (int i = MAX_LEN - 1; i >= 1; i--) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = new_x;
                seg_y_d[0] = new_y;
                if (grow) begin
                    len_d = len_q + 1'b1;
                    tr_d  = 1'b1;
                end
            end
        end

        // Query uses the current (pre-move) segments.
        pix_d = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (LW'(i) < len_q && seg_x_q[i] == ADDR_X && seg_y_q[i] == ADDR_Y)
                pix_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= X_WIDTH'(GRID_X / 2);
                seg_y_q[i] <= Y_WIDTH'(GRID_Y / 2 + ((i < INIT_LEN) ? i : INIT_LEN - 1));
            end
            len_q  <= LW'(INIT_LEN);
            cnt_q  <= '0;
            coll_q <= 1'b0;
            tr_q   <= 1'b0;
            pix_q  <= 1'b0;
        end else begin
            seg_x_q <= seg_x_d;
            seg_y_q <= seg_y_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            coll_q  <= coll_d;
            tr_q    <= tr_d;
            pix_q   <= pix_d;
        end
    end

    assign HEAD_X         = seg_x_q[0];
    assign HEAD_Y         = seg_y_q[0];
    assign LENGTH         = len_q;
    assign MOVE_TICK      = tick & ~RESET;
    assign TARGET_REACHED = tr_q;
    assign COLLISION      = coll_q;
    assign SNAKE_PIXEL    = pix_q;

endmodule

// File: tb/tb_snake_motion_controller.sv
// Self-checking bench for snake_motion_controller (MOVE_PERIOD = 4).
// A queue-based body model predicts each move; expectations are pushed to
// scoreboard queues on the tick and popped when the DUT result is visible.
module tb_snake_motion_controller;

    localparam logic [1:0] UP = 2'd0, LEFT = 2'd1, RIGHT = 2'd2, DOWN = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] nav;
    logic       ga;
    logic [7:0] tgx, adx, hx;
    logic [6:0] tgy, ady, hy;
    logic [4:0] len;
    logic       mt, tr, col, snake_pixel;

    always #5 clk = ~clk;

    snake_motion_controller #(.MOVE_PERIOD(4)) dut (
        .CLK(clk), .RESET(rst), .NAV_STATE(nav), .GAME_ACTIVE(ga),
        .TARGET_X(tgx), .TARGET_Y(tgy), .ADDR_X(adx), .ADDR_Y(ady),
        .HEAD_X(hx), .HEAD_Y(hy), .LENGTH(len), .MOVE_TICK(mt),
        .TARGET_REACHED(tr), .COLLISION(col), .SNAKE_PIXEL(snake_pixel)
    );

    typedef struct {
        int hx; int hy; int len; int coll; int tr;
    } exp_t;

    exp_t sbq[$];
    int   pixq[$];
    int   bx[$], by[$];
    int   mcoll;
    int   tx, ty;
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        bx.delete(); by.delete();
        for (int i = 0; i < 4; i++) begin
            bx.push_back(80);
            by.push_back(60 + i);
        end
        mcoll = 0;
    endtask

    task automatic set_target(input int x, input int y);
        tx = x; ty = y;
        tgx = 8'(x); tgy = 7'(y);
    endtask

    task automatic rst_check();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_head_x", int'(hx), 80);
        chk("rst_head_y", int'(hy), 60);
        chk("rst_len", int'(len), 4);
        chk("rst_tick", int'(mt), 0);
        chk("rst_tr", int'(tr), 0);
        chk("rst_coll", int'(col), 0);
        chk("rst_pix", int'(snake_pixel), 0);
        rst = 1'b0;
        model_reset();
    endtask

    // Called at a negedge; returns at the negedge two cycles after the tick.
    task automatic do_move(input logic [1:0] dir, output int waited);
        exp_t e, g;
        int   nx, ny, lim;
        bit   grow, hit;
        nav = dir;
        waited = 0;
        while (!mt && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!mt) begin
            chk("tick_timeout", 0, 1);
            return;
        end
        chk("tr_idle", int'(tr), 0);
        nx = bx[0]; ny = by[0];
        case (dir)
            UP:      ny = (ny == 0)   ? 119 : ny - 1;
            DOWN:    ny = (ny == 119) ? 0   : ny + 1;
            LEFT:    nx = (nx == 0)   ? 159 : nx - 1;
            default: nx = (nx == 159) ? 0   : nx + 1;
        endcase
        grow = (nx == tx) && (ny == ty) && (bx.size() < 16);
        lim  = grow ? bx.size() : bx.size() - 1;
        hit  = 0;
        for (int i = 1; i < lim; i++)
            if (bx[i] == nx && by[i] == ny) hit = 1;
        if (hit) begin
            mcoll = 1;
            e.tr = 0;
        end else begin
            bx.push_front(nx); by.push_front(ny);
            if (!grow) begin
                void'(bx.pop_back()); void'(by.pop_back());
            end
            e.tr = int'(grow);
        end
        e.hx = bx[0]; e.hy = by[0]; e.len = bx.size(); e.coll = mcoll;
        sbq.push_back(e);
        @(negedge clk);
        g = sbq.pop_front();
        chk("head_x", int'(hx), g.hx);
        chk("head_y", int'(hy), g.hy);
        chk("length", int'(len), g.len);
        chk("collision", int'(col), g.coll);
        chk("target_reached", int'(tr), g.tr);
        @(negedge clk);
        chk("tr_width", int'(tr), 0);
    endtask

    task automatic run(input logic [1:0] dir, input int n);
        int w;
        for (int k = 0; k < n; k++) begin
            do_move(dir, w);
            chk("gap", w, 2);
        end
    endtask

    task automatic pix_check(input int x, input int y);
        int e = 0;
        adx = 8'(x); ady = 7'(y);
        for (int i = 0; i < bx.size(); i++)
            if (bx[i] == x && by[i] == y) e = 1;
        pixq.push_back(e);
        @(negedge clk);
        chk("pixel", int'(snake_pixel), pixq.pop_front());
    endtask

    task automatic count_ticks(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (mt) n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, n;
        rst = 1'b1; ga = 1'b0; nav = UP; adx = '0; ady = '0;
        set_target(80, 59);
        model_reset();
        @(negedge clk);
        rst_check();

        // Occupancy queries on the reset body (80,60..63).
        pix_check(80, 62);
        pix_check(80, 64);
        pix_check(81, 60);
        pix_check(80, 63);

        // First tick after 4 counted cycles; grows onto the target.
        ga = 1'b1;
        do_move(UP, w);
        chk("first_tick_wait", w, 3);
        chk("grow_len", int'(len), 5);
        chk("grow_head_y", int'(hy), 59);

        // Tail retained by the grow; then a 12-cycle pause mid-period.
        ga = 1'b0;
        pix_check(80, 63);
        pix_check(80, 64);
        count_ticks(10, n);
        chk("pause_ticks", n, 0);
        set_target(100, 100);
        ga = 1'b1;
        do_move(UP, w);
        chk("resume_wait", w, 2);

        // Travel to the edges to exercise wrap-around.
        run(LEFT, 80);
        run(UP, 48);
        run(LEFT, 1);
        chk("wrap_left_x", int'(hx), 159);
        chk("wrap_left_y", int'(hy), 10);
        run(LEFT, 154);
        run(DOWN, 109);
        chk("pre_wrap_down_y", int'(hy), 119);
        run(DOWN, 1);
        chk("wrap_down_x", int'(hx), 5);
        chk("wrap_down_y", int'(hy), 0);

        // Reset while running, then grow to 5 and steer into the body.
        rst_check();
        set_target(80, 59);
        do_move(UP, w);
        chk("rst_first_wait", w, 3);
        run(UP, 1);
        run(LEFT, 1);
        run(DOWN, 1);
        run(RIGHT, 1);
        chk("coll_flag", int'(col), 1);
        chk("coll_head_x", int'(hx), 79);
        chk("coll_head_y", int'(hy), 59);
        chk("coll_len", int'(len), 5);
        count_ticks(12, n);
        chk("coll_no_tick", n, 0);
        chk("coll_sticky", int'(col), 1);
        rst_check();

        // Feed the target directly ahead until the length saturates.
        for (int k = 0; k < 13; k++) begin
            set_target(80, 59 - k);
            do_move(UP, w);
            chk("maxlen_gap", w, (k == 0) ? 3 : 2);
        end
        chk("maxlen_len", int'(len), 16);
        chk("maxlen_head_y", int'(hy), 47);
        ga = 1'b0;
        pix_check(80, 62);
        pix_check(80, 63);
        pix_check(80, 47);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
